ed_spike_detector: RTL and testbench



---
 rtl/ed_spike_detector.sv | 186 ++++++++++++++++++
 tb/tb_ed_spike_detector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ed_spike_detector.sv
`default_nettype none
// ============================================================================
// Module   : ed_spike_detector
// Brief    : Turns the unsigned energy-of-derivative stream into discrete
//            spike events. An EMA noise floor sets an adaptive threshold.
//            A three-state FSM tracks each supra-threshold excursion, emits
//            one pulse with the peak energy and its timestamp, then holds off
//            for a refractory period.
//            Optional build macro: ED_DET_MAX_LEN_EN caps event length at
//            MAX_LEN accepted samples (undefined: no length limit).
// Revision : 1.0 - initial release
// ============================================================================
module ed_spike_detector #(
  parameter int IN_BITS     = 29,
  parameter int AVG_SH      = 6,
  parameter int THR_MULT_SH = 3,
  parameter int MIN_THR     = 1024,
  parameter int REFRACT     = 32,
  parameter int TS_BITS     = 32,
  parameter int MAX_LEN     = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [IN_BITS-1:0] energy_in,
  output logic               spike,
  output logic [IN_BITS-1:0] spike_peak,
  output logic [TS_BITS-1:0] spike_ts,
  output logic [IN_BITS-1:0] threshold,
  output logic               busy
);

  // Accumulator holds 2^AVG_SH times the average, so it never overflows.
  localparam int c_ACC_W = IN_BITS + AVG_SH;
  localparam int c_SH_W  = IN_BITS + THR_MULT_SH;
  localparam int c_CNT_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ABOVE   = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_ACC_W-1:0]   r_acc;
  logic [TS_BITS-1:0]   r_ts;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [IN_BITS-1:0]   r_peak;
  logic [TS_BITS-1:0]   r_peak_ts;
  logic                 r_spike;
  logic [IN_BITS-1:0]   r_spike_peak;
  logic [TS_BITS-1:0]   r_spike_ts;
  logic [IN_BITS-1:0]   r_thr;

  logic [IN_BITS-1:0]   w_avg;
  logic [c_SH_W-1:0]    w_sh;
  logic [IN_BITS-1:0]   w_sat;
  logic [IN_BITS-1:0]   w_thr_nxt;
  logic                 w_above;
  logic                 w_new_max;
  logic                 w_take;
  logic                 w_end;
  logic                 w_acc_en;
  logic [IN_BITS-1:0]   w_best_peak;
  logic [TS_BITS-1:0]   w_best_ts;

`ifdef ED_DET_MAX_LEN_EN
  localparam int c_LEN_W = $clog2(MAX_LEN + 1);
  logic [c_LEN_W-1:0]   r_len;
`else
  logic                 w_unused_max_len;
  assign w_unused_max_len = (MAX_LEN > 0);
`endif

  // Threshold candidate: avg shifted up, saturated to IN_BITS, floored at MIN_THR.
  assign w_avg     = IN_BITS'(r_acc >> AVG_SH);
  assign w_sh      = c_SH_W'(w_avg) << THR_MULT_SH;
  assign w_sat     = (w_sh > c_SH_W'({IN_BITS{1'b1}})) ? {IN_BITS{1'b1}} : w_sh[IN_BITS-1:0];
  assign w_thr_nxt = (w_sat < IN_BITS'(MIN_THR)) ? IN_BITS'(MIN_THR) : w_sat;

  assign w_above   = energy_in > r_thr;
  assign w_new_max = energy_in > r_peak;

  // Peak reported at event end includes the current sample when it is taken.
  assign w_best_peak = w_take ? energy_in : r_peak;
  assign w_best_ts   = w_take ? r_ts      : r_peak_ts;

  // Next-state and per-sample control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_end       = 1'b0;
    w_acc_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_acc_en = 1'b1;
          if (w_above) begin
            w_take      = 1'b1;
            w_state_nxt = ST_ABOVE;
`ifdef ED_DET_MAX_LEN_EN
            if (MAX_LEN <= 1) w_end = 1'b1;
`endif
          end
        end
      end
      ST_ABOVE: begin
        if (in_valid) begin
          if (!w_above) begin
            // Terminating sample never contributes to the peak.
            w_end = 1'b1;
          end else begin
            w_take = w_new_max;
`ifdef ED_DET_MAX_LEN_EN
            if (r_len >= c_LEN_W'(MAX_LEN - 1)) w_end = 1'b1;
`endif
          end
        end
      end
      ST_REFRACT: begin
        if (in_valid && (r_cnt <= c_CNT_W'(1))) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_end) w_state_nxt = (REFRACT == 0) ? ST_IDLE : ST_REFRACT;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: noise floor, timestamp, peak tracking, refractory count, outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_ts         <= '0;
      r_cnt        <= '0;
      r_peak       <= '0;
      r_peak_ts    <= '0;
      r_spike      <= 1'b0;
      r_spike_peak <= '0;
      r_spike_ts   <= '0;
      r_thr        <= IN_BITS'(MIN_THR);
    end else begin
      r_thr   <= w_thr_nxt;
      r_spike <= w_end;
      if (w_acc_en) r_acc <= r_acc - (r_acc >> AVG_SH) + c_ACC_W'(energy_in);
      if (in_valid) r_ts <= r_ts + TS_BITS'(1);
      if (w_take) begin
        r_peak    <= energy_in;
        r_peak_ts <= r_ts;
      end
      if (w_end) begin
        r_spike_peak <= w_best_peak;
        r_spike_ts   <= w_best_ts;
        r_cnt        <= c_CNT_W'(REFRACT);
      end else if ((r_state == ST_REFRACT) && in_valid) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
    end
  end

`ifdef ED_DET_MAX_LEN_EN
  // Event length: trigger sample counts as 1, held while idle at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= c_LEN_W'(1);
    end else if (r_state == ST_IDLE) begin
      r_len <= c_LEN_W'(1);
    end else if ((r_state == ST_ABOVE) && in_valid) begin
      r_len <= r_len + c_LEN_W'(1);
    end
  end
`endif

  assign spike      = r_spike;
  assign spike_peak = r_spike_peak;
  assign spike_ts   = r_spike_ts;
  assign threshold  = r_thr;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ed_spike_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ed_spike_detector
// Brief    : Self-checking bench for ed_spike_detector. A main instance and a
//            4-bit-timestamp instance share one stimulus stream; both are
//            compared each cycle against an event-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ed_spike_detector;

  localparam int IN_BITS     = 29;
  localparam int AVG_SH      = 6;
  localparam int THR_MULT_SH = 3;
  localparam int MIN_THR     = 1024;
  localparam int REFRACT     = 32;
  localparam int MAX_LEN     = 4;
  localparam longint MAXV    = (64'd1 << IN_BITS) - 1;
`ifdef ED_DET_MAX_LEN_EN
  localparam bit c_LIM = 1'b1;
`else
  localparam bit c_LIM = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [IN_BITS-1:0] energy_in = '0;
  logic               spike, busy, spike_w, busy_w;
  logic [IN_BITS-1:0] spike_peak, threshold, peak_w, thr_w;
  logic [31:0]        spike_ts;
  logic [3:0]         ts_w;

  always #5 clk = ~clk;

  ed_spike_detector #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .energy_in(energy_in),
    .spike(spike), .spike_peak(spike_peak), .spike_ts(spike_ts),
    .threshold(threshold), .busy(busy)
  );

  ed_spike_detector #(.TS_BITS(4), .MAX_LEN(MAX_LEN)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .energy_in(energy_in),
    .spike(spike_w), .spike_peak(peak_w), .spike_ts(ts_w),
    .threshold(thr_w), .busy(busy_w)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model (event level) ----------------
  typedef struct { longint e; longint ts; } samp_t;
  samp_t  m_ev[$];
  longint m_acc, m_thr, m_ts, m_sp_peak, m_sp_ts;
  int     m_mode;   // 0 idle, 1 inside event, 2 hold-off
  int     m_rem;
  bit     m_spike;

  function automatic void m_reset();
    m_acc = 0; m_thr = MIN_THR; m_ts = 0; m_mode = 0; m_rem = 0;
    m_spike = 0; m_sp_peak = 0; m_sp_ts = 0; m_ev.delete();
  endfunction

  function automatic void m_close();
    longint bp = -1;
    longint bt = 0;
    foreach (m_ev[i]) if (m_ev[i].e > bp) begin bp = m_ev[i].e; bt = m_ev[i].ts; end
    m_spike = 1; m_sp_peak = bp; m_sp_ts = bt; m_ev.delete();
    if (REFRACT == 0) m_mode = 0;
    else begin m_mode = 2; m_rem = REFRACT; end
  endfunction

  function automatic void m_edge(input bit r, input bit v, input longint e);
    longint nt;
    if (r) begin m_reset(); return; end
    nt = (m_acc / (64'd1 << AVG_SH)) * (64'd1 << THR_MULT_SH);
    if (nt > MAXV) nt = MAXV;
    if (nt < MIN_THR) nt = MIN_THR;
    m_spike = 0;
    if (v) begin
      if (m_mode == 0) begin
        m_acc = m_acc - m_acc / (64'd1 << AVG_SH) + e;
        if (e > m_thr) begin
          m_mode = 1;
          m_ev.push_back('{e, m_ts});
          if (c_LIM && m_ev.size() >= MAX_LEN) m_close();
        end
      end else if (m_mode == 1) begin
        if (e <= m_thr) m_close();
        else begin
          m_ev.push_back('{e, m_ts});
          if (c_LIM && m_ev.size() >= MAX_LEN) m_close();
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end
      m_ts++;
    end
    m_thr = nt;
  endfunction

  // Apply one cycle of stimulus, advance the model, compare both instances.
  task automatic step(input bit r, input bit v, input longint e);
    rst = r; in_valid = v; energy_in = IN_BITS'(e);
    @(posedge clk);
    #1;
    m_edge(r, v, e);
    chk("spike", spike, m_spike);
    chk("busy", busy, m_mode != 0);
    chk("threshold", threshold, m_thr);
    chk("spike_peak", spike_peak, m_sp_peak);
    chk("spike_ts", spike_ts, m_sp_ts % (64'd1 << 32));
    chk("w_spike", spike_w, m_spike);
    chk("w_spike_ts", ts_w, m_sp_ts % 16);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct { bit r; bit v; int e; bit c; bit xs; int xp; int xt; bit xb; } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit r, input bit v, input int e, input bit c,
                              input bit xs, input int xp, input int xt, input bit xb);
    tbl.push_back('{r, v, e, c, xs, xp, xt, xb});
  endfunction

  function automatic void zeros(input int n);
    for (int i = 0; i < n; i++) add(0, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    // Single event
    add(1, 0, 0, 1, 0, 0, 0, 0);
    zeros(10);
    add(0, 1, 5000, 1, 0, 0, 0, 1);
    add(0, 1, 0,    1, 1, 5000, 10, 1);
    add(0, 0, 0,    1, 0, 5000, 10, 1);
    // Multi-sample event with a tied peak
    add(1, 0, 0, 1, 0, 0, 0, 0);
    zeros(20);
    add(0, 1, 2000, 1, 0, 0, 0, 1);
    add(0, 1, 6000, 0, 0, 0, 0, 0);
    add(0, 1, 6000, 0, 0, 0, 0, 0);
    add(0, 1, 3000, 0, 0, 0, 0, 0);
    add(0, 1, 0,    1, 1, 6000, 21, 1);
    // Refractory hold-off
    add(1, 0, 0, 1, 0, 0, 0, 0);
    zeros(29);
    add(0, 1, 9000, 1, 0, 0, 0, 1);
    add(0, 1, 0,    1, 1, 9000, 29, 1);
    zeros(9);
    add(0, 1, 9000, 1, 0, 9000, 29, 1);
    zeros(20);
    add(0, 1, 0,    1, 0, 9000, 29, 1);
    add(0, 1, 0,    1, 0, 9000, 29, 0);
    zeros(7);
    add(0, 1, 9000, 1, 0, 9000, 29, 1);
    add(0, 1, 0,    1, 1, 9000, 70, 1);
    // in_valid gap inside an event
    add(1, 0, 0, 1, 0, 0, 0, 0);
    zeros(10);
    add(0, 1, 5000, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0,    1, 1, 5000, 10, 1);
    // Equality does not trigger
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1024, 1, 0, 0, 0, 0);
    add(0, 1, 1025, 1, 0, 0, 0, 1);
    add(0, 1, 0,    1, 1, 1025, 1, 1);
    // Reset mid-event discards the event
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 5000, 1, 0, 0, 0, 1);
    add(0, 1, 6000, 0, 0, 0, 0, 0);
    add(1, 1, 0,    1, 0, 0, 0, 0);
    add(0, 1, 0,    1, 0, 0, 0, 0);
    // Long event: capped or not depending on build
    add(1, 0, 0, 1, 0, 0, 0, 0);
`ifdef ED_DET_MAX_LEN_EN
    for (int i = 0; i < 3; i++) add(0, 1, 7000, 1, 0, 0, 0, 1);
    add(0, 1, 7000, 1, 1, 7000, 0, 1);
    add(0, 1, 7000, 1, 0, 7000, 0, 1);
    add(0, 1, 7000, 1, 0, 7000, 0, 1);
    add(0, 1, 0,    1, 0, 7000, 0, 1);
`else
    for (int i = 0; i < 6; i++) add(0, 1, 7000, 1, 0, 0, 0, 1);
    add(0, 1, 0,    1, 1, 7000, 0, 1);
`endif

    m_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].e);
      if (tbl[i].c) begin
        chk("tbl_spike", spike, tbl[i].xs);
        chk("tbl_busy", busy, tbl[i].xb);
        chk("tbl_peak", spike_peak, tbl[i].xp);
        chk("tbl_ts", spike_ts, tbl[i].xt);
        if (tbl[i].r) chk("tbl_reset_thr", threshold, MIN_THR);
      end
    end

    // Adaptive threshold settles near 8 x 1000
    step(1, 0, 0);
    for (int i = 0; i < 2000; i++) step(0, 1, 1000);
    step(0, 0, 0);
    chk("adapt_thr_in_range", (threshold >= 7936 && threshold <= 8000), 1);
    step(0, 1, 5000);
    chk("adapt_5000_no_trigger", busy, 0);
    step(0, 1, 9000);
    chk("adapt_9000_trigger", busy, 1);
    step(0, 1, 0);
    chk("adapt_spike", spike, 1);
    chk("adapt_peak", spike_peak, 9000);

    // Timestamp wrap on the 4-bit instance
    step(1, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 0);
    step(0, 1, 5000);
    step(0, 1, 9000);
    step(0, 1, 0);
    chk("wrap_spike", spike_w, 1);
    chk("wrap_ts4", ts_w, 0);
    chk("wrap_ts32", spike_ts, 16);

    // Randomized traffic against the model
    step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit     r, v;
      longint e;
      int     k;
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 9) < 8);
      k = $urandom_range(0, 99);
      if (k < 70)      e = $urandom_range(0, 1500);
      else if (k < 95) e = $urandom_range(0, 30000);
      else             e = longint'($urandom) & MAXV;
      step(r, v, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
